// File: rtl/fir_pkg.sv
// Shared types and helpers for the programmable N-tap FIR stream filter.
package fir_pkg;

    localparam logic MODE_FIR = 1'b0;
    localparam logic MODE_SUM = 1'b1;

    // Container wide enough for any supported coefficient index (up to 255 taps).
    localparam int FIR_ADDR_MAX_W = 8;
    typedef logic [FIR_ADDR_MAX_W-1:0] fir_coef_addr_t;

    function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_filter_pipe_if.sv
// Valid/ready stream bundle between the sample source, the FIR and the downstream DSP stage.
interface fir_filter_pipe_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] Din;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Dout;

    modport master (
        output in_valid, Din, out_ready,
        input  in_ready, out_valid, Dout
    );

    modport slave (
        input  in_valid, Din, out_ready,
        output in_ready, out_valid, Dout
    );
endinterface

// File: rtl/fir_coef_bank.sv
// TAPS x COEF_W coefficient registers, all reset to 1, with a single write port.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int TAPS   = 4,
    parameter int COEF_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [$clog2(TAPS)-1:0]  i_addr,
    input  logic [COEF_W-1:0]        i_wdata,
    output logic [TAPS*COEF_W-1:0]   o_coef
);

    logic [COEF_W-1:0] r_coef [TAPS];
    fir_coef_addr_t    w_addr;

    assign w_addr = fir_coef_addr_t'(i_addr);

    // Out-of-range indices can only occur when TAPS is not a power of two; they are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TAPS; i++) r_coef[i] <= COEF_W'(1);
        end else if (i_we && (w_addr < fir_coef_addr_t'(TAPS))) begin
            r_coef[i_addr] <= i_wdata;
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_flat
        assign o_coef[g*COEF_W +: COEF_W] = r_coef[g];
    end

endmodule

// File: rtl/fir_filter_pipe.sv
// Two-stage pipelined FIR / moving-sum filter on a valid/ready stream.
// Define FIR_SAT_EN to clip the scaled output to DATA_W bits and expose sat_flag; otherwise the output wraps.
module fir_filter_pipe
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int RSHIFT = 0
) (
    input  logic                    CLK,
    input  logic                    reset,
    fir_filter_pipe_if.slave        io,
    input  logic                    mode,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_wdata,
    input  logic                    flush
`ifdef FIR_SAT_EN
    ,
    output logic                    sat_flag
`endif
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = fir_acc_w(DATA_W, COEF_W, TAPS);

`ifdef FIR_SAT_EN
    function automatic logic f_clip(input logic [ACC_W-1:0] acc);
        return (acc >> RSHIFT) > ACC_W'({DATA_W{1'b1}});
    endfunction

    function automatic logic [DATA_W-1:0] f_scale(input logic [ACC_W-1:0] acc);
        return f_clip(acc) ? '1 : DATA_W'(acc >> RSHIFT);
    endfunction
`else
    function automatic logic [DATA_W-1:0] f_scale(input logic [ACC_W-1:0] acc);
        return DATA_W'(acc >> RSHIFT);
    endfunction
`endif

    logic [DATA_W-1:0]      r_tap_p0 [TAPS];
    logic [PROD_W-1:0]      r_prod_p1 [TAPS];
    logic                   r_vld_p0;
    logic                   r_vld_p1;
    logic                   r_vld_p2;
    logic [DATA_W-1:0]      r_dout_p2;
`ifdef FIR_SAT_EN
    logic                   r_sat_p2;
`endif
    logic [TAPS*COEF_W-1:0] w_coef;
    logic [PROD_W-1:0]      w_prod [TAPS];
    logic [ACC_W-1:0]       w_acc;
    logic                   w_stall;
    logic                   w_accept;

    fir_coef_bank #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W)
    ) u_coef_bank (
        .i_clk   (CLK),
        .i_rst_n (reset),
        .i_we    (coef_we),
        .i_addr  (coef_addr),
        .i_wdata (coef_wdata),
        .o_coef  (w_coef)
    );

    assign w_stall     = r_vld_p2 & ~io.out_ready;
    assign w_accept    = io.in_valid & ~w_stall;
    assign io.in_ready = ~w_stall;
    assign io.out_valid = r_vld_p2;
    assign io.Dout      = r_dout_p2;
`ifdef FIR_SAT_EN
    assign sat_flag     = r_sat_p2;
`endif

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            w_prod[i] = (mode == MODE_SUM) ? PROD_W'(r_tap_p0[i])
                      : PROD_W'(r_tap_p0[i]) * PROD_W'(w_coef[i*COEF_W +: COEF_W]);
        end
    end

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < TAPS; i++) w_acc = w_acc + ACC_W'(r_prod_p1[i]);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_tap_p0[i]  <= '0;
                r_prod_p1[i] <= '0;
            end
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_dout_p2 <= '0;
`ifdef FIR_SAT_EN
            r_sat_p2  <= 1'b0;
`endif
        end else if (flush) begin
            for (int i = 0; i < TAPS; i++) begin
                r_tap_p0[i]  <= '0;
                r_prod_p1[i] <= '0;
            end
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (!w_stall) begin
            // p0: delay line shifts only on an accepted sample
            if (w_accept) begin
                r_tap_p0[0] <= io.Din;
                for (int i = 1; i < TAPS; i++) r_tap_p0[i] <= r_tap_p0[i-1];
            end
            r_vld_p0 <= w_accept;
            // p1: products
            for (int i = 0; i < TAPS; i++) r_prod_p1[i] <= w_prod[i];
            r_vld_p1 <= r_vld_p0;
            // p2: sum and scale; Dout only moves on a real sample
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_dout_p2 <= f_scale(w_acc);
`ifdef FIR_SAT_EN
                r_sat_p2  <= f_clip(w_acc);
`endif
            end
        end
    end

endmodule
